// File: rtl/bram_port_arbiter.sv
// bram_port_arbiter
// Shares one BRAM port between two requesters: req0 (clip loader) and
// req1 (PL writer/readback). Single-word commands are serialised with
// round-robin tie breaking. A locked burst keeps the grant with its owner
// until a beat with lock=0 is accepted, or until the owner has been idle
// for LOCK_TIMEOUT cycles. Read data returns to the issuing requester
// BRAM_DELAY+1 edges after the accept edge, in issue order.
//
// Ports
//   clk, rst                    clock, async active-high reset
//   reqN_valid_i/ready_o        command handshake (N=0,1)
//   reqN_addr_i/we_i/be_i       command address, write flag, byte enables
//   reqN_wdata_i, reqN_lock_i   write data, keep grant after this beat
//   rdN_valid_o, rdN_data_o     one-cycle read response strobe and data
//   BRAM_*_o, BRAM_dout_i       BRAM port
//   lock_timeout_err_o          sticky flag, set on forced lock release
//
// state     | meaning
// ST_OPEN   | no lock; any valid requester may win (round-robin on ties)
// ST_LOCKED | only owner_q may be granted; idle timer counts down
module bram_port_arbiter #(
   parameter int ADDR_W       = 32,
   parameter int DATA_W       = 32,
   parameter int BRAM_DELAY   = 2,
   parameter int LOCK_TIMEOUT = 256
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                req0_valid_i,
   output logic                req0_ready_o,
   input  logic [ADDR_W-1:0]   req0_addr_i,
   input  logic                req0_we_i,
   input  logic [DATA_W/8-1:0] req0_be_i,
   input  logic [DATA_W-1:0]   req0_wdata_i,
   input  logic                req0_lock_i,
   input  logic                req1_valid_i,
   output logic                req1_ready_o,
   input  logic [ADDR_W-1:0]   req1_addr_i,
   input  logic                req1_we_i,
   input  logic [DATA_W/8-1:0] req1_be_i,
   input  logic [DATA_W-1:0]   req1_wdata_i,
   input  logic                req1_lock_i,
   output logic                rd0_valid_o,
   output logic [DATA_W-1:0]   rd0_data_o,
   output logic                rd1_valid_o,
   output logic [DATA_W-1:0]   rd1_data_o,
   output logic                BRAM_clk_o,
   output logic [ADDR_W-1:0]   BRAM_addr_o,
   output logic [DATA_W-1:0]   BRAM_din_o,
   output logic                BRAM_en_o,
   output logic [DATA_W/8-1:0] BRAM_we_o,
   output logic                BRAM_rst_o,
   input  logic [DATA_W-1:0]   BRAM_dout_i,
   output logic                lock_timeout_err_o
);

   localparam int BE_W  = DATA_W / 8;
   localparam int CNT_W = (LOCK_TIMEOUT > 1) ? $clog2(LOCK_TIMEOUT) : 1;
   localparam logic [CNT_W-1:0] IDLE_LOAD = CNT_W'(LOCK_TIMEOUT - 1);

   localparam logic [0:0] ST_OPEN   = 1'b0;
   localparam logic [0:0] ST_LOCKED = 1'b1;

   logic [0:0]       state_q, state_d;
   logic             owner_q, owner_d;
   logic             last_q, last_d;
   logic [CNT_W-1:0] idle_q, idle_d;
   logic             err_q, err_d;

   logic grant0, grant1, acc;
   logic [ADDR_W-1:0] sel_addr;
   logic [DATA_W-1:0] sel_wdata;
   logic [BE_W-1:0]   sel_be;
   logic              sel_we, sel_lock;

   logic [ADDR_W-1:0] bram_addr_q;
   logic [DATA_W-1:0] bram_din_q;
   logic              bram_en_q;
   logic [BE_W-1:0]   bram_we_q;
   logic              bram_rst_q;

   // Entry [0] is aligned with the BRAM_en cycle; entry [BRAM_DELAY] is the
   // cycle BRAM_dout carries that command's data.
   logic [BRAM_DELAY:0] resp_vld_q, resp_id_q;
   logic                rd0_valid_q, rd1_valid_q;
   logic [DATA_W-1:0]   rd0_data_q, rd1_data_q;

   always_comb begin
      grant0 = 1'b0;
      grant1 = 1'b0;
      if (state_q == ST_LOCKED) begin
         grant0 = ~owner_q & req0_valid_i;
         grant1 =  owner_q & req1_valid_i;
      end else if (req0_valid_i && req1_valid_i) begin
         grant0 =  last_q;
         grant1 = ~last_q;
      end else begin
         grant0 = req0_valid_i;
         grant1 = req1_valid_i;
      end
   end

   // Ready is held low for the whole reset window, even with valid high.
   assign req0_ready_o = grant0 & ~rst;
   assign req1_ready_o = grant1 & ~rst;
   assign acc          = grant0 | grant1;

   assign sel_addr  = grant1 ? req1_addr_i  : req0_addr_i;
   assign sel_wdata = grant1 ? req1_wdata_i : req0_wdata_i;
   assign sel_be    = grant1 ? req1_be_i    : req0_be_i;
   assign sel_we    = grant1 ? req1_we_i    : req0_we_i;
   assign sel_lock  = grant1 ? req1_lock_i  : req0_lock_i;

   always_comb begin
      state_d = state_q;
      owner_d = owner_q;
      last_d  = last_q;
      idle_d  = idle_q;
      err_d   = err_q;
      if (acc) begin
         owner_d = grant1;
         last_d  = grant1;
         state_d = sel_lock ? ST_LOCKED : ST_OPEN;
         idle_d  = IDLE_LOAD;
      end else if (state_q == ST_LOCKED) begin
         // No accept while locked means the owner is idle this cycle.
         if (idle_q == '0) begin
            state_d = ST_OPEN;
            err_d   = 1'b1;
         end else begin
            idle_d = idle_q - 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_OPEN;
         owner_q <= 1'b0;
         last_q  <= 1'b1;
         idle_q  <= IDLE_LOAD;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         owner_q <= owner_d;
         last_q  <= last_d;
         idle_q  <= idle_d;
         err_q   <= err_d;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bram_addr_q <= '0;
         bram_din_q  <= '0;
         bram_en_q   <= 1'b0;
         bram_we_q   <= '0;
         bram_rst_q  <= 1'b1;
      end else begin
         bram_rst_q <= 1'b0;
         bram_en_q  <= acc;
         bram_we_q  <= (acc && sel_we) ? sel_be : '0;
         if (acc) begin
            bram_addr_q <= sel_addr;
            bram_din_q  <= sel_wdata;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         resp_vld_q  <= '0;
         resp_id_q   <= '0;
         rd0_valid_q <= 1'b0;
         rd1_valid_q <= 1'b0;
         rd0_data_q  <= '0;
         rd1_data_q  <= '0;
      end else begin
         resp_vld_q  <= {resp_vld_q[BRAM_DELAY-1:0], acc & ~sel_we};
         resp_id_q   <= {resp_id_q[BRAM_DELAY-1:0], grant1};
         rd0_valid_q <= resp_vld_q[BRAM_DELAY] & ~resp_id_q[BRAM_DELAY];
         rd1_valid_q <= resp_vld_q[BRAM_DELAY] &  resp_id_q[BRAM_DELAY];
         if (resp_vld_q[BRAM_DELAY] && !resp_id_q[BRAM_DELAY])
            rd0_data_q <= BRAM_dout_i;
         if (resp_vld_q[BRAM_DELAY] && resp_id_q[BRAM_DELAY])
            rd1_data_q <= BRAM_dout_i;
      end
   end

   assign BRAM_clk_o         = clk;
   assign BRAM_addr_o        = bram_addr_q;
   assign BRAM_din_o         = bram_din_q;
   assign BRAM_en_o          = bram_en_q;
   assign BRAM_we_o          = bram_we_q;
   assign BRAM_rst_o         = bram_rst_q;
   assign rd0_valid_o        = rd0_valid_q;
   assign rd1_valid_o        = rd1_valid_q;
   assign rd0_data_o         = rd0_data_q;
   assign rd1_data_o         = rd1_data_q;
   assign lock_timeout_err_o = err_q;

endmodule

// File: tb/tb_bram_port_arbiter.sv
// Testbench for bram_port_arbiter: a 64-word BRAM model with two register
// stages of read latency, a per-requester read scoreboard, a table of
// arbitration vectors, and directed sequences for bursts, byte-enable
// writes, lock timeout, mid-flight reset and idle behaviour.
module tb_bram_port_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        v0, rdy0, we0, l0, v1, rdy1, we1, l1;
   logic [31:0] a0, a1, wd0, wd1;
   logic [3:0]  be0, be1;
   logic        rd0v, rd1v;
   logic [31:0] rd0d, rd1d;
   logic        bclk, ben, brst, err;
   logic [31:0] baddr, bdin, bdout;
   logic [3:0]  bwe;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;
   int rd0_cnt  = 0;
   int first_rd0 = -1;
   int last_rd0  = -1;

   logic [31:0] exp0_q[$];
   logic [31:0] exp1_q[$];

   logic [31:0] mem [64];
   logic [31:0] d1;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   bram_port_arbiter dut (
      .clk(clk), .rst(rst),
      .req0_valid_i(v0), .req0_ready_o(rdy0), .req0_addr_i(a0), .req0_we_i(we0),
      .req0_be_i(be0), .req0_wdata_i(wd0), .req0_lock_i(l0),
      .req1_valid_i(v1), .req1_ready_o(rdy1), .req1_addr_i(a1), .req1_we_i(we1),
      .req1_be_i(be1), .req1_wdata_i(wd1), .req1_lock_i(l1),
      .rd0_valid_o(rd0v), .rd0_data_o(rd0d), .rd1_valid_o(rd1v), .rd1_data_o(rd1d),
      .BRAM_clk_o(bclk), .BRAM_addr_o(baddr), .BRAM_din_o(bdin), .BRAM_en_o(ben),
      .BRAM_we_o(bwe), .BRAM_rst_o(brst), .BRAM_dout_i(bdout),
      .lock_timeout_err_o(err)
   );

   function automatic logic [31:0] f(int i);
      return 32'hC0DE_0000 | 32'(i);
   endfunction

   function automatic logic [31:0] merge(logic [31:0] old, logic [31:0] din, logic [3:0] be);
      logic [31:0] w = old;
      for (int b = 0; b < 4; b++)
         if (be[b]) w[8*b +: 8] = din[8*b +: 8];
      return w;
   endfunction

   // BRAM model: read-first, dout valid two edges after the en-high cycle.
   always @(posedge bclk) begin
      if (rst) begin
         for (int i = 0; i < 64; i++) mem[i] <= f(i);
      end else if (ben) begin
         mem[baddr[7:2]] <= merge(mem[baddr[7:2]], bdin, bwe);
      end
      if (ben) d1 <= mem[baddr[7:2]];
      bdout <= d1;
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   always @(negedge clk) begin
      logic [31:0] e;
      if (rd0v) begin
         rd0_cnt++;
         if (first_rd0 < 0) first_rd0 = cyc;
         last_rd0 = cyc;
         if (exp0_q.size() == 0) begin
            n_checks++; n_fail++;
            $display("FAIL rd0_unexpected: got data %0h expected no response", rd0d);
         end else begin
            e = exp0_q.pop_front();
            check("rd0_data", rd0d, e);
         end
      end
      if (rd1v) begin
         if (exp1_q.size() == 0) begin
            n_checks++; n_fail++;
            $display("FAIL rd1_unexpected: got data %0h expected no response", rd1d);
         end else begin
            e = exp1_q.pop_front();
            check("rd1_data", rd1d, e);
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   typedef struct {
      logic v0, l0, v1, l1, r0, r1;
   } vec_t;
   vec_t vecs[21];

   task automatic check_reset_outputs(input string tag);
      check({tag, "_rdy0"}, rdy0, 0);
      check({tag, "_rdy1"}, rdy1, 0);
      check({tag, "_rd0v"}, rd0v, 0);
      check({tag, "_rd1v"}, rd1v, 0);
      check({tag, "_rd0d"}, rd0d, 0);
      check({tag, "_rd1d"}, rd1d, 0);
      check({tag, "_en"}, ben, 0);
      check({tag, "_we"}, bwe, 0);
      check({tag, "_addr"}, baddr, 0);
      check({tag, "_din"}, bdin, 0);
      check({tag, "_brst"}, brst, 1);
      check({tag, "_err"}, err, 0);
   endtask

   initial begin
      int acc_cyc;
      int bad;
      rst = 1'b1;
      v0 = 0; we0 = 0; l0 = 0; a0 = 0; wd0 = 0; be0 = 0;
      v1 = 0; we1 = 0; l1 = 0; a1 = 0; wd1 = 0; be1 = 0;

      //           v0 l0 v1 l1 r0 r1
      vecs[0]  = '{0, 0, 0, 0, 0, 0};
      vecs[1]  = '{1, 0, 1, 0, 1, 0};
      vecs[2]  = '{1, 0, 1, 0, 0, 1};
      vecs[3]  = '{1, 0, 1, 0, 1, 0};
      vecs[4]  = '{1, 0, 1, 0, 0, 1};
      vecs[5]  = '{1, 0, 1, 0, 1, 0};
      vecs[6]  = '{1, 0, 1, 0, 0, 1};
      vecs[7]  = '{1, 0, 1, 0, 1, 0};
      vecs[8]  = '{1, 0, 1, 0, 0, 1};
      vecs[9]  = '{0, 0, 1, 0, 0, 1};
      vecs[10] = '{0, 0, 1, 0, 0, 1};
      vecs[11] = '{1, 0, 1, 0, 1, 0};
      vecs[12] = '{1, 1, 0, 0, 1, 0};
      vecs[13] = '{0, 0, 1, 0, 0, 0};
      vecs[14] = '{1, 0, 1, 0, 1, 0};
      vecs[15] = '{1, 0, 1, 0, 0, 1};
      vecs[16] = '{0, 0, 1, 1, 0, 1};
      vecs[17] = '{1, 0, 0, 0, 0, 0};
      vecs[18] = '{1, 0, 1, 0, 0, 1};
      vecs[19] = '{1, 0, 1, 0, 1, 0};
      vecs[20] = '{0, 0, 0, 0, 0, 0};

      repeat (3) @(negedge clk);
      #1 check_reset_outputs("por");
      @(negedge clk) rst = 1'b0;
      @(posedge clk) #1 check("brst_release", brst, 0);

      // Arbitration table: req0 reads word 0, req1 reads word 1.
      a0 = 32'h0; a1 = 32'h4;
      for (int i = 0; i < 21; i++) begin
         @(negedge clk);
         v0 = vecs[i].v0; l0 = vecs[i].l0; v1 = vecs[i].v1; l1 = vecs[i].l1;
         #1;
         check($sformatf("tbl%0d_rdy0", i), rdy0, vecs[i].r0);
         check($sformatf("tbl%0d_rdy1", i), rdy1, vecs[i].r1);
         if (vecs[i].r0) exp0_q.push_back(f(0));
         if (vecs[i].r1) exp1_q.push_back(f(1));
         @(posedge clk);
         #1;
         check($sformatf("tbl%0d_en", i), ben, vecs[i].r0 | vecs[i].r1);
         check($sformatf("tbl%0d_we", i), bwe, 0);
      end
      v0 = 0; v1 = 0; l0 = 0; l1 = 0;
      repeat (6) @(negedge clk);

      // Locked 64-word burst by req0 while req1 keeps requesting.
      rd0_cnt = 0; first_rd0 = -1; last_rd0 = -1; bad = 0; acc_cyc = 0;
      for (int i = 0; i < 64; i++) begin
         @(negedge clk);
         v0 = 1; a0 = 32'(i * 4); l0 = (i != 63);
         v1 = (i != 0); a1 = 32'h4;
         #1;
         check($sformatf("burst%0d_rdy0", i), rdy0, 1);
         if (rdy1) bad++;
         exp0_q.push_back(f(i));
         @(posedge clk);
         #1 if (i == 0) acc_cyc = cyc;
      end
      @(negedge clk);
      v0 = 0; l0 = 0;
      #1 check("lock_release_rdy1", rdy1, 1);
      exp1_q.push_back(f(1));
      @(negedge clk) v1 = 0;
      repeat (6) @(negedge clk);
      check("burst_rdy1_low", 64'(bad), 0);
      check("burst_rd0_count", 64'(rd0_cnt), 64);
      check("burst_consecutive", 64'(last_rd0 - first_rd0), 63);
      check("burst_latency", 64'(first_rd0 - acc_cyc), 3);

      // Byte-enable write by req1, then readback by req0.
      @(negedge clk);
      v1 = 1; we1 = 1; a1 = 32'h10; be1 = 4'b0011; wd1 = 32'hDEAD_BEEF; l1 = 0;
      #1 check("wr_rdy1", rdy1, 1);
      @(posedge clk);
      #1;
      check("wr_en", ben, 1);
      check("wr_we", bwe, 4'b0011);
      check("wr_addr", baddr, 32'h10);
      check("wr_din", bdin, 32'hDEAD_BEEF);
      @(negedge clk);
      v1 = 0; we1 = 0; be1 = 0;
      v0 = 1; we0 = 0; a0 = 32'h10; be0 = 4'b1111;
      #1 check("rb_rdy0", rdy0, 1);
      exp0_q.push_back(32'hC0DE_BEEF);
      @(posedge clk);
      #1 check("rb_we", bwe, 0);
      @(negedge clk) v0 = 0; be0 = 0;
      @(posedge clk);
      #1;
      check("hold_en", ben, 0);
      check("hold_addr", baddr, 32'h10);
      repeat (6) @(negedge clk);

      // Lock timeout: req0 locks then goes idle while req1 waits.
      @(negedge clk);
      v0 = 1; l0 = 1; a0 = 32'h0; v1 = 0;
      #1 check("to_lock_rdy0", rdy0, 1);
      exp0_q.push_back(f(0));
      bad = 0;
      for (int n = 1; n <= 256; n++) begin
         @(negedge clk);
         v0 = 0; l0 = 0; v1 = 1; a1 = 32'h4;
         #1;
         if (rdy1) bad++;
         if (n == 256) check("to_err_before", err, 0);
      end
      check("to_rdy1_held", 64'(bad), 0);
      @(negedge clk);
      #1;
      check("to_rdy1_257", rdy1, 1);
      check("to_err_set", err, 1);
      exp1_q.push_back(f(1));
      @(negedge clk) v1 = 0;
      repeat (8) @(negedge clk);
      check("to_err_sticky", err, 1);

      // Reset with two reads in flight.
      @(negedge clk);
      v0 = 1; v1 = 1; a0 = 32'h0; a1 = 32'h4;
      #1 check("rf_rdy0", rdy0, 1);
      @(negedge clk);
      #1 check("rf_rdy1", rdy1, 1);
      @(negedge clk);
      rst = 1'b1;
      #1 check_reset_outputs("midrst");
      v0 = 0; v1 = 0;
      repeat (3) @(negedge clk);
      #1 check_reset_outputs("midrst_hold");
      @(negedge clk) rst = 1'b0;
      @(posedge clk) #1 check("midrst_brst_release", brst, 0);
      repeat (6) @(negedge clk);

      // Idle: nothing valid for 10 cycles.
      bad = 0;
      for (int n = 0; n < 10; n++) begin
         @(negedge clk);
         #1;
         if (ben !== 1'b0 || bwe !== 4'b0 || rdy0 !== 1'b0 || rdy1 !== 1'b0) bad++;
      end
      check("idle_quiet", 64'(bad), 0);
      check("exp0_drained", 64'(exp0_q.size()), 0);
      check("exp1_drained", 64'(exp1_q.size()), 0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
